// File: rtl/instr_decode_pipe_if.sv
// rtl/instr_decode_pipe_if.sv - fetch, write-back and ID/EX signal bundle for instr_decode_pipe
//
// Fetch side : in_valid/in_ready handshake, instr, ctrl_in and decode flags.
// Write-back : wb_we, wb_vec, wb_rd, wb_data.
// Control    : flush kills the ID/EX bundle.
// EX side    : out_valid/out_ready handshake plus the registered decoded bundle.
// slave  = decode stage, master = surrounding pipeline.
interface instr_decode_pipe_if #(
   parameter int XLEN   = 32,
   parameter int VW     = 256,
   parameter int CTRL_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [CTRL_W-1:0] ctrl_in;
   logic              use_rs1;
   logic              use_rs2;
   logic              rs2_from_rd;
   logic              src_vec;
   logic              wr_en;
   logic              wr_vec;
   logic              wb_we;
   logic              wb_vec;
   logic [4:0]        wb_rd;
   logic [VW-1:0]     wb_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [XLEN-1:0]   out_rs1;
   logic [XLEN-1:0]   out_rs2;
   logic [VW-1:0]     out_vs1;
   logic [VW-1:0]     out_vs2;
   logic [XLEN-1:0]   out_imm;
   logic [XLEN-1:0]   out_addr;
   logic [4:0]        out_rd;
   logic              out_wr_en;
   logic              out_wr_vec;

   modport slave (
      input  in_valid, instr, ctrl_in, use_rs1, use_rs2, rs2_from_rd, src_vec,
             wr_en, wr_vec, wb_we, wb_vec, wb_rd, wb_data, flush, out_ready,
      output in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_vs1, out_vs2,
             out_imm, out_addr, out_rd, out_wr_en, out_wr_vec
   );

   modport master (
      output in_valid, instr, ctrl_in, use_rs1, use_rs2, rs2_from_rd, src_vec,
             wr_en, wr_vec, wb_we, wb_vec, wb_rd, wb_data, flush, out_ready,
      input  in_ready, out_valid, out_ctrl, out_rs1, out_rs2, out_vs1, out_vs2,
             out_imm, out_addr, out_rd, out_wr_en, out_wr_vec
   );
endinterface

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - pipelined instruction decode with register files, scoreboard and ID/EX stage
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - instr_decode_pipe_if.slave: fetch handshake, decode flags, write-back port,
//          flush, and the registered ID/EX bundle with its valid/ready handshake
//
// Scalar and vector register files are read combinationally with write-back bypass.
// A per-file scoreboard marks destinations of issued instructions until written back;
// RAW hazards against the scoreboard or the bundle sitting in ID/EX stall fetch.
module instr_decode_pipe #(
   parameter int XLEN   = 32,
   parameter int LANES  = 8,
   parameter int LANE_W = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 16
) (
   input logic                 clk,
   input logic                 rst,
   instr_decode_pipe_if.slave  bus
);
   localparam int VW = LANES * LANE_W;

   logic [XLEN-1:0] rf_s [NREG];
   logic [VW-1:0]   rf_v [NREG];
   logic [NREG-1:0] sb_s, sb_v;
   logic [NREG-1:0] sb_s_nxt, sb_v_nxt;

   logic [4:0] rd, rs1, rs2;
   logic       wb_s, wb_v;
   logic [XLEN-1:0] rd_s1, rd_s2;
   logic [VW-1:0]   rd_v1, rd_v2;
   logic busy1, busy2, clr1, clr2, pend1, pend2, hazard;
   logic fire, issue;

   assign rd  = bus.instr[26:22];
   assign rs1 = bus.instr[21:17];
   assign rs2 = bus.rs2_from_rd ? bus.instr[26:22] : bus.instr[16:12];

   assign wb_s = bus.wb_we & ~bus.wb_vec;
   assign wb_v = bus.wb_we &  bus.wb_vec;

   // Scalar r0 is hard-wired to zero, so it also bypasses nothing.
   assign rd_s1 = (rs1 == 5'd0) ? '0 :
                  (wb_s && bus.wb_rd == rs1) ? bus.wb_data[XLEN-1:0] : rf_s[rs1];
   assign rd_s2 = (rs2 == 5'd0) ? '0 :
                  (wb_s && bus.wb_rd == rs2) ? bus.wb_data[XLEN-1:0] : rf_s[rs2];
   assign rd_v1 = (wb_v && bus.wb_rd == rs1) ? bus.wb_data : rf_v[rs1];
   assign rd_v2 = (wb_v && bus.wb_rd == rs2) ? bus.wb_data : rf_v[rs2];

   // Hazards only look at the file the sources are read from; scalar r0 never blocks.
   assign busy1 = bus.src_vec ? sb_v[rs1] : sb_s[rs1];
   assign busy2 = bus.src_vec ? sb_v[rs2] : sb_s[rs2];
   assign clr1  = bus.wb_we && (bus.wb_vec == bus.src_vec) && (bus.wb_rd == rs1);
   assign clr2  = bus.wb_we && (bus.wb_vec == bus.src_vec) && (bus.wb_rd == rs2);
   assign pend1 = bus.out_valid && bus.out_wr_en && (bus.out_wr_vec == bus.src_vec) &&
                  (bus.out_rd == rs1) && (bus.src_vec || rs1 != 5'd0);
   assign pend2 = bus.out_valid && bus.out_wr_en && (bus.out_wr_vec == bus.src_vec) &&
                  (bus.out_rd == rs2) && (bus.src_vec || rs2 != 5'd0);

   assign hazard = (bus.use_rs1 && ((busy1 && !clr1) || pend1)) ||
                   (bus.use_rs2 && ((busy2 && !clr2) || pend2));

   assign bus.in_ready = rst && (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
   assign fire  = bus.in_valid && bus.in_ready;
   // A flushed bundle never reaches EX, so it must not mark its destination busy.
   assign issue = bus.out_valid && bus.out_ready && !bus.flush;

   // Clear first, then set, so an issue and a write-back to the same index leave it busy.
   always_comb begin
      sb_s_nxt = sb_s;
      sb_v_nxt = sb_v;
      if (wb_s) sb_s_nxt[bus.wb_rd] = 1'b0;
      if (wb_v) sb_v_nxt[bus.wb_rd] = 1'b0;
      if (issue && bus.out_wr_en) begin
         if (bus.out_wr_vec)
            sb_v_nxt[bus.out_rd] = 1'b1;
         else if (bus.out_rd != 5'd0)
            sb_s_nxt[bus.out_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_s <= '0;
         sb_v <= '0;
      end else begin
         sb_s <= sb_s_nxt;
         sb_v <= sb_v_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_s[i] <= '0;
            rf_v[i] <= '0;
         end
      end else if (bus.wb_we) begin
         if (bus.wb_vec)
            rf_v[bus.wb_rd] <= bus.wb_data;
         else if (bus.wb_rd != 5'd0)
            rf_s[bus.wb_rd] <= bus.wb_data[XLEN-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_ctrl   <= '0;
         bus.out_rs1    <= '0;
         bus.out_rs2    <= '0;
         bus.out_vs1    <= '0;
         bus.out_vs2    <= '0;
         bus.out_imm    <= '0;
         bus.out_addr   <= '0;
         bus.out_rd     <= '0;
         bus.out_wr_en  <= 1'b0;
         bus.out_wr_vec <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (fire) begin
         bus.out_valid  <= 1'b1;
         bus.out_ctrl   <= bus.ctrl_in;
         bus.out_rs1    <= rd_s1;
         bus.out_rs2    <= rd_s2;
         bus.out_vs1    <= rd_v1;
         bus.out_vs2    <= rd_v2;
         bus.out_imm    <= {{(XLEN-16){bus.instr[16]}}, bus.instr[16:1]};
         bus.out_addr   <= {{(XLEN-27){1'b0}}, bus.instr[26:0]};
         bus.out_rd     <= rd;
         bus.out_wr_en  <= bus.wr_en;
         bus.out_wr_vec <= bus.wr_vec;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - randomized and directed bench for instr_decode_pipe against a reference model
module tb_instr_decode_pipe;
   localparam int XLEN   = 32;
   localparam int LANES  = 8;
   localparam int LANE_W = 32;
   localparam int NREG   = 32;
   localparam int CTRL_W = 16;
   localparam int VW     = LANES * LANE_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_decode_pipe_if #(.XLEN(XLEN), .VW(VW), .CTRL_W(CTRL_W)) bus ();

   instr_decode_pipe #(.XLEN(XLEN), .LANES(LANES), .LANE_W(LANE_W), .NREG(NREG), .CTRL_W(CTRL_W))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   typedef struct {
      bit              v;
      bit [CTRL_W-1:0] ctrl;
      bit [XLEN-1:0]   rs1, rs2, imm, addr;
      bit [VW-1:0]     vs1, vs2;
      bit [4:0]        rd;
      bit              wr, wrv;
   } bundle_t;

   bit [XLEN-1:0] m_rs [NREG];
   bit [VW-1:0]   m_rv [NREG];
   bit            m_bs [NREG];
   bit            m_bv [NREG];
   bundle_t       m_out;

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_rs[i] = '0; m_rv[i] = '0; m_bs[i] = 1'b0; m_bv[i] = 1'b0;
      end
      m_out = '{default: '0};
   endfunction

   function automatic logic [4:0] src1();
      return bus.instr[21:17];
   endfunction

   function automatic logic [4:0] src2();
      return bus.rs2_from_rd ? bus.instr[26:22] : bus.instr[16:12];
   endfunction

   function automatic bit [XLEN-1:0] read_s(input logic [4:0] idx);
      if (idx == 5'd0) return '0;
      if (bus.wb_we && !bus.wb_vec && bus.wb_rd == idx) return bus.wb_data[XLEN-1:0];
      return m_rs[idx];
   endfunction

   function automatic bit [VW-1:0] read_v(input logic [4:0] idx);
      if (bus.wb_we && bus.wb_vec && bus.wb_rd == idx) return bus.wb_data;
      return m_rv[idx];
   endfunction

   function automatic bit blocked(input logic [4:0] idx, input bit vec);
      bit busy, clearing, pend;
      if (!vec && idx == 5'd0) return 1'b0;
      busy     = vec ? m_bv[idx] : m_bs[idx];
      clearing = bus.wb_we && (bus.wb_vec == vec) && (bus.wb_rd == idx);
      pend     = m_out.v && m_out.wr && (m_out.wrv == vec) && (m_out.rd == idx);
      return (busy && !clearing) || pend;
   endfunction

   function automatic bit exp_ready();
      bit hz;
      hz = (bus.use_rs1 && blocked(src1(), bus.src_vec)) ||
           (bus.use_rs2 && blocked(src2(), bus.src_vec));
      return (!m_out.v || bus.out_ready) && !hz && !bus.flush;
   endfunction

   // One clock: compare at the falling edge, advance the model, then let the DUT clock.
   task automatic step();
      bundle_t nb;
      bit rdy, fire, issue;
      int im;
      @(negedge clk);
      if (!rst) begin
         check("rst_out_valid", VW'(bus.out_valid), VW'(1'b0));
         model_reset();
      end else begin
         rdy = exp_ready();
         check("in_ready", VW'(bus.in_ready), VW'(rdy));
         check("out_valid", VW'(bus.out_valid), VW'(m_out.v));
         if (m_out.v) begin
            check("out_ctrl",   VW'(bus.out_ctrl),   VW'(m_out.ctrl));
            check("out_rs1",    VW'(bus.out_rs1),    VW'(m_out.rs1));
            check("out_rs2",    VW'(bus.out_rs2),    VW'(m_out.rs2));
            check("out_vs1",    bus.out_vs1,         m_out.vs1);
            check("out_vs2",    bus.out_vs2,         m_out.vs2);
            check("out_imm",    VW'(bus.out_imm),    VW'(m_out.imm));
            check("out_addr",   VW'(bus.out_addr),   VW'(m_out.addr));
            check("out_rd",     VW'(bus.out_rd),     VW'(m_out.rd));
            check("out_wr_en",  VW'(bus.out_wr_en),  VW'(m_out.wr));
            check("out_wr_vec", VW'(bus.out_wr_vec), VW'(m_out.wrv));
         end
         fire  = bus.in_valid && rdy;
         issue = m_out.v && bus.out_ready && !bus.flush;
         nb = '{default: '0};
         if (fire) begin
            nb.v    = 1'b1;
            nb.ctrl = bus.ctrl_in;
            nb.rs1  = read_s(src1());
            nb.rs2  = read_s(src2());
            nb.vs1  = read_v(src1());
            nb.vs2  = read_v(src2());
            im = int'(bus.instr[16:1]);
            if (im >= 32768) im = im - 65536;
            nb.imm  = XLEN'(im);
            nb.addr = bus.instr & 32'h07FF_FFFF;
            nb.rd   = bus.instr[26:22];
            nb.wr   = bus.wr_en;
            nb.wrv  = bus.wr_vec;
         end
         if (bus.wb_we) begin
            if (bus.wb_vec) begin
               m_rv[bus.wb_rd] = bus.wb_data;
               m_bv[bus.wb_rd] = 1'b0;
            end else begin
               if (bus.wb_rd != 5'd0) m_rs[bus.wb_rd] = bus.wb_data[XLEN-1:0];
               m_bs[bus.wb_rd] = 1'b0;
            end
         end
         if (issue && m_out.wr) begin
            if (m_out.wrv) m_bv[m_out.rd] = 1'b1;
            else if (m_out.rd != 5'd0) m_bs[m_out.rd] = 1'b1;
         end
         if (bus.flush) m_out.v = 1'b0;
         else if (fire) m_out = nb;
         else if (bus.out_ready) m_out.v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0; bus.instr = '0; bus.ctrl_in = '0;
      bus.use_rs1 = 1'b0; bus.use_rs2 = 1'b0; bus.rs2_from_rd = 1'b0; bus.src_vec = 1'b0;
      bus.wr_en = 1'b0; bus.wr_vec = 1'b0;
      bus.wb_we = 1'b0; bus.wb_vec = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
   endtask

   function automatic logic [VW-1:0] rand_vw();
      logic [VW-1:0] v;
      for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic drive_random();
      bus.in_valid     = ($urandom_range(0, 9) < 7);
      bus.instr        = $urandom;
      bus.instr[26:22] = 5'($urandom_range(0, 7));
      bus.instr[21:17] = 5'($urandom_range(0, 7));
      bus.instr[16:12] = 5'($urandom_range(0, 7));
      bus.ctrl_in      = CTRL_W'($urandom);
      bus.use_rs1      = 1'($urandom);
      bus.use_rs2      = 1'($urandom);
      bus.rs2_from_rd  = 1'($urandom);
      bus.src_vec      = 1'($urandom);
      bus.wr_en        = 1'($urandom);
      bus.wr_vec       = 1'($urandom);
      bus.wb_we        = ($urandom_range(0, 3) == 0);
      bus.wb_vec       = 1'($urandom);
      bus.wb_rd        = 5'($urandom_range(0, 7));
      bus.wb_data      = rand_vw();
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.out_ready    = ($urandom_range(0, 9) < 7);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      #2 rst = 1'b0;
      #1;
      check("reset_out_valid", VW'(bus.out_valid), VW'(1'b0));
      check("reset_in_ready",  VW'(bus.in_ready),  VW'(1'b0));
      check("reset_out_ctrl",  VW'(bus.out_ctrl),  VW'(1'b0));
      check("reset_out_rs1",   VW'(bus.out_rs1),   VW'(1'b0));
      check("reset_out_vs2",   bus.out_vs2,        VW'(1'b0));
      repeat (2) step();
      rst = 1'b1;

      // immediate sign extension and address zero extension
      idle(); bus.in_valid = 1'b1; bus.instr = 32'h0001_0002;
      step();
      bus.instr = 32'h07FF_FFFF;
      check("imm_sext", VW'(bus.out_imm), VW'(32'hFFFF_8001));
      step();
      check("addr_zext", VW'(bus.out_addr), VW'(32'h07FF_FFFF));
      idle(); step();

      // RAW on r5 released by a same-cycle write-back with bypass
      idle(); bus.in_valid = 1'b1; bus.wr_en = 1'b1; bus.instr = 32'd5 << 22;
      step();
      bus.wr_en = 1'b0; bus.use_rs1 = 1'b1; bus.instr = 32'd5 << 17;
      #1 check("raw_pending", VW'(bus.in_ready), VW'(1'b0));
      step();
      #1 check("raw_busy", VW'(bus.in_ready), VW'(1'b0));
      step();
      bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = VW'(32'h1234);
      #1 check("raw_wb_ready", VW'(bus.in_ready), VW'(1'b1));
      step();
      check("raw_bypass", VW'(bus.out_rs1), VW'(32'h1234));
      idle(); step();

      // back-pressure holds the bundle, then one transfer per cycle
      idle(); bus.in_valid = 1'b1; bus.ctrl_in = 16'hA5A5;
      step();
      bus.out_ready = 1'b0; bus.ctrl_in = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", VW'(bus.in_ready), VW'(1'b0));
         check("bp_hold", VW'(bus.out_ctrl), VW'(16'hA5A5));
         step();
      end
      bus.out_ready = 1'b1;
      step();
      check("bp_resume", VW'(bus.out_ctrl), VW'(16'h1111));
      for (int i = 0; i < 3; i++) begin
         bus.ctrl_in = 16'(16'h2000 + i);
         step();
         check("bp_stream", VW'(bus.out_ctrl), VW'(16'(16'h2000 + i)));
      end
      idle(); step();

      // flush of a held v3 writer leaves v3 free
      idle(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.wr_en = 1'b1; bus.wr_vec = 1'b1;
      bus.instr = 32'd3 << 22;
      step();
      bus.in_valid = 1'b0; bus.wr_en = 1'b0; bus.wr_vec = 1'b0;
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("flush_valid", VW'(bus.out_valid), VW'(1'b0));
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.src_vec = 1'b1; bus.use_rs1 = 1'b1;
      bus.instr = 32'd3 << 17;
      #1 check("flush_no_stall", VW'(bus.in_ready), VW'(1'b1));
      step();
      idle(); step();

      // scalar r7 in flight does not block vector v7
      idle(); bus.in_valid = 1'b1; bus.wr_en = 1'b1; bus.instr = 32'd7 << 22;
      step();
      bus.wr_en = 1'b0; bus.src_vec = 1'b1; bus.use_rs1 = 1'b1; bus.instr = 32'd7 << 17;
      #1 check("xfile_ready", VW'(bus.in_ready), VW'(1'b1));
      step();
      idle(); step();

      // r0 is never busy and always reads zero
      idle(); bus.in_valid = 1'b1; bus.wr_en = 1'b1; bus.instr = 32'd0;
      step();
      bus.wr_en = 1'b0; bus.use_rs1 = 1'b1;
      bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = VW'(32'hFFFF_FFFF);
      #1 check("r0_ready", VW'(bus.in_ready), VW'(1'b1));
      step();
      check("r0_read", VW'(bus.out_rs1), VW'(1'b0));
      idle(); bus.in_valid = 1'b1; bus.use_rs1 = 1'b1;
      #1 check("r0_not_busy", VW'(bus.in_ready), VW'(1'b1));
      step();
      idle(); step();

      for (int i = 0; i < 1500; i++) begin
         drive_random();
         step();
      end

      // asynchronous reset with a valid bundle in ID/EX
      idle(); step();
      idle(); bus.in_valid = 1'b1;
      step();
      check("pre_rst_valid", VW'(bus.out_valid), VW'(1'b1));
      rst = 1'b0;
      #1;
      check("mid_rst_valid", VW'(bus.out_valid), VW'(1'b0));
      check("mid_rst_ctrl",  VW'(bus.out_ctrl),  VW'(1'b0));
      check("mid_rst_rs1",   VW'(bus.out_rs1),   VW'(1'b0));
      check("mid_rst_vs1",   bus.out_vs1,        VW'(1'b0));
      check("mid_rst_imm",   VW'(bus.out_imm),   VW'(1'b0));
      check("mid_rst_addr",  VW'(bus.out_addr),  VW'(1'b0));
      check("mid_rst_rd",    VW'(bus.out_rd),    VW'(1'b0));
      model_reset();
      idle();
      step();
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.use_rs1 = 1'b1; bus.instr = 32'd5 << 17;
      step();
      check("post_rst_rs1", VW'(bus.out_rs1), VW'(1'b0));
      bus.src_vec = 1'b1; bus.instr = 32'd3 << 17;
      step();
      check("post_rst_vs1", bus.out_vs1, VW'(1'b0));
      idle(); step();

      for (int i = 0; i < 300; i++) begin
         drive_random();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
